// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the two-street traffic-light subsystem:
//   - chan_state_e : per-street sensor channel state encoding (3 bits)
//   - DEF_*        : default timing constants for the sensor conditioner
//   - GREEN/YELLOW/RED : lamp encodings used by the light controller
//   - max3()       : helper used to size channel counters
// No ports (package).
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    PRESENT = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } chan_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 8;
  localparam int DEF_STUCK_CYCLES    = 1000;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// -----------------------------------------------------------------------------
// traffic_sensor_conditioner_if
// Bundles the raw detector inputs, the fault-clear request and the
// conditioned outputs of the sensor conditioner.
//   master : stimulus side (drives raw_a, raw_b, fault_clr; observes outputs)
//   slave  : conditioner side (consumes inputs; drives TA, TB, fault_a, fault_b)
// -----------------------------------------------------------------------------
interface traffic_sensor_conditioner_if;
  logic raw_a;
  logic raw_b;
  logic fault_clr;
  logic TA;
  logic TB;
  logic fault_a;
  logic fault_b;

  modport master (
    output raw_a, raw_b, fault_clr,
    input  TA, TB, fault_a, fault_b
  );

  modport slave (
    input  raw_a, raw_b, fault_clr,
    output TA, TB, fault_a, fault_b
  );
endinterface

// File: rtl/sensor_channel.sv
// -----------------------------------------------------------------------------
// sensor_channel
// One street's detector conditioning: 2-flop synchronizer, rise debounce,
// fall hold-extension and stuck-sensor fault trap.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   raw       in  asynchronous loop detector level (1 = vehicle)
//   fault_clr in  single-cycle request to leave FAULT (honoured only if raw low)
//   t         out conditioned presence (PRESENT or HOLD)
//   fault     out channel latched faulty
// -----------------------------------------------------------------------------
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic fault_clr,
  output logic t,
  output logic fault
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STK_LAST  = CNT_W'(STUCK_CYCLES - 1);

  logic              sync1_r;
  logic              sync2_r;
  chan_state_e       state_r;
  chan_state_e       state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              t_r;
  logic              t_next_s;
  logic              fault_r;
  logic              fault_next_s;

  // Two-flop synchronizer for the asynchronous detector level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // State, counter and output flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      t_r     <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      t_r     <= t_next_s;
      fault_r <= fault_next_s;
    end
  end

  // Next-state and counter logic; the counter restarts on every state change.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (sync2_r) begin
          state_next_s = QUAL;
          cnt_next_s   = CNT_ONE;
        end else begin
          cnt_next_s   = CNT_ZERO;
        end
      end
      QUAL: begin
        if (!sync2_r) begin
          state_next_s = IDLE;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_next_s = PRESENT;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      PRESENT: begin
        if (!sync2_r) begin
          state_next_s = HOLD;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == STK_LAST) begin
          state_next_s = FAULT;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      HOLD: begin
        // Returning traffic goes straight back to PRESENT so T has no gap.
        if (sync2_r) begin
          state_next_s = PRESENT;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == HOLD_LAST) begin
          state_next_s = IDLE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      FAULT: begin
        // A clear while the loop still reads occupied is dropped, not queued.
        if (fault_clr && !sync2_r) begin
          state_next_s = IDLE;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s   = CNT_ZERO;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so the flags register with the state.
  always_comb begin
    t_next_s     = (state_next_s == PRESENT) || (state_next_s == HOLD);
    fault_next_s = (state_next_s == FAULT);
  end

  assign t     = t_r;
  assign fault = fault_r;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// traffic_sensor_conditioner
// Produces clean TA/TB presence inputs for the light FSM from raw loop
// detectors. Two independent sensor_channel instances; fault_clr is shared.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  slave modport: raw_a, raw_b, fault_clr in; TA, TB, fault_a, fault_b out
// -----------------------------------------------------------------------------
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input logic                          clk,
  input logic                          rst,
  traffic_sensor_conditioner_if.slave  bus
);

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_ch_a (
    .clk       (clk),
    .rst       (rst),
    .raw       (bus.raw_a),
    .fault_clr (bus.fault_clr),
    .t         (bus.TA),
    .fault     (bus.fault_a)
  );

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_ch_b (
    .clk       (clk),
    .rst       (rst),
    .raw       (bus.raw_b),
    .fault_clr (bus.fault_clr),
    .t         (bus.TB),
    .fault     (bus.fault_b)
  );

endmodule
